// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scanner: double-buffered digit data, blank time
// between digits, PWM brightness, per-digit blink and selectable pin polarity.
module seg_scan_ctrl #(
  parameter int unsigned N_DIG        = 4,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYC    = 64,
  parameter int unsigned BRIGHT_W     = 4,
  parameter int unsigned BLINK_FRAMES = 64,
  parameter bit          SEG_ACT_LOW  = 1'b1,
  parameter bit          CS_ACT_LOW   = 1'b1
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic [4*N_DIG-1:0]    dig_val,
  input  logic [N_DIG-1:0]      dig_dot,
  input  logic [N_DIG-1:0]      dig_ena,
  input  logic [N_DIG-1:0]      dig_blink,
  input  logic [BRIGHT_W-1:0]   brightness,
  input  logic                  upd_req,
  output logic                  upd_ack,
  output logic [7:0]            seg_pin,
  output logic [N_DIG-1:0]      segcs_pin,
  output logic                  frame_tick
);

  localparam int unsigned CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W   = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam int unsigned FRM_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int unsigned PROD_W  = CNT_W + BRIGHT_W + 1;
  localparam int unsigned ON_SPAN = SCAN_DIV - BLANK_CYC;

  localparam logic [7:0]       SEG_OFF = SEG_ACT_LOW ? 8'hFF : 8'h00;
  localparam logic [N_DIG-1:0] CS_OFF  = CS_ACT_LOW ? {N_DIG{1'b1}} : {N_DIG{1'b0}};

  typedef enum logic [1:0] {PH_BLANK, PH_ON, PH_OFF} phase_t;

  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [IDX_W-1:0]    idx, idx_nxt;
  logic                cnt_last, idx_last, frame_wrap;
  logic [FRM_W-1:0]    blink_cnt;
  logic                blink_phase;

  logic [4*N_DIG-1:0]  val_sh;
  logic [N_DIG-1:0]    dot_sh, ena_sh, blink_sh;
  logic [BRIGHT_W-1:0] bright_sh;

  logic [PROD_W-1:0]   on_len, on_end;
  phase_t              phase;
  logic                shown;
  logic [3:0]          nibble;
  logic [7:0]          seg_pat, seg_nxt;
  logic [N_DIG-1:0]    cs_on, cs_nxt, cs_act;
  logic                seg_load;

  // Hex nibble to active-high {g,f,e,d,c,b,a}
  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] p;
    case (v)
      4'h0: p = 7'h3F;
      4'h1: p = 7'h06;
      4'h2: p = 7'h5B;
      4'h3: p = 7'h4F;
      4'h4: p = 7'h66;
      4'h5: p = 7'h6D;
      4'h6: p = 7'h7D;
      4'h7: p = 7'h07;
      4'h8: p = 7'h7F;
      4'h9: p = 7'h6F;
      4'hA: p = 7'h77;
      4'hB: p = 7'h7C;
      4'hC: p = 7'h39;
      4'hD: p = 7'h5E;
      4'hE: p = 7'h79;
      default: p = 7'h71;
    endcase
    return p;
  endfunction

  // Slot counter and digit index next values
  always_comb begin
    cnt_last   = (cnt == CNT_W'(SCAN_DIV - 1));
    idx_last   = (idx == IDX_W'(N_DIG - 1));
    frame_wrap = cnt_last && idx_last;
    cnt_nxt    = cnt_last ? '0 : cnt + CNT_W'(1);
    idx_nxt    = idx;
    if (cnt_last) idx_nxt = idx_last ? '0 : idx + IDX_W'(1);
  end

  // Slot and digit counters
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= cnt_nxt;
      idx <= idx_nxt;
    end
  end

  // Frame-boundary state: blink phase, brightness sample and shadow load
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      bright_sh   <= '0;
      val_sh      <= '0;
      dot_sh      <= '0;
      ena_sh      <= '0;
      blink_sh    <= '0;
    end else if (frame_wrap) begin
      bright_sh <= brightness;
      if (blink_cnt == FRM_W'(BLINK_FRAMES - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + FRM_W'(1);
      end
      if (upd_req) begin
        val_sh   <= dig_val;
        dot_sh   <= dig_dot;
        ena_sh   <= dig_ena;
        blink_sh <= dig_blink;
      end
    end
  end

  // Slot phase from cnt and the frame's brightness
  always_comb begin
    on_len = (PROD_W'(ON_SPAN) * (PROD_W'(bright_sh) + PROD_W'(1))) >> BRIGHT_W;
    on_end = PROD_W'(BLANK_CYC) + on_len;
    phase  = PH_OFF;
    if (PROD_W'(cnt) < PROD_W'(BLANK_CYC)) phase = PH_BLANK;
    else if (PROD_W'(cnt) < on_end)        phase = PH_ON;
  end

  // Next pin values; segments reload only once the selects are already off
  always_comb begin
    shown    = ena_sh[idx] && !(blink_sh[idx] && blink_phase);
    nibble   = val_sh[4*idx +: 4];
    seg_pat  = {dot_sh[idx], seg_decode(nibble)};
    seg_nxt  = SEG_ACT_LOW ? ~seg_pat : seg_pat;
    cs_on    = (phase == PH_ON && shown) ? (N_DIG'(1) << idx) : '0;
    cs_nxt   = CS_ACT_LOW ? ~cs_on : cs_on;
    cs_act   = CS_ACT_LOW ? ~segcs_pin : segcs_pin;
    seg_load = (phase == PH_BLANK) && (cs_act == '0);
  end

  // Registered pins and status pulses
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      seg_pin    <= SEG_OFF;
      segcs_pin  <= CS_OFF;
      upd_ack    <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      segcs_pin  <= cs_nxt;
      if (seg_load) seg_pin <= seg_nxt;
      upd_ack    <= frame_wrap && upd_req;
      frame_tick <= (cnt_nxt == CNT_W'(SCAN_DIV - 1)) && (idx_nxt == IDX_W'(N_DIG - 1));
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with a 4-digit, 16-cycle-slot configuration.
module tb_seg_scan_ctrl;

  logic        clk;
  logic        RST;
  logic [15:0] dig_val;
  logic [3:0]  dig_dot, dig_ena, dig_blink;
  logic [1:0]  brightness;
  logic        upd_req;
  logic        upd_ack;
  logic [7:0]  seg_pin;
  logic [3:0]  segcs_pin;
  logic        frame_tick;

  int n_cmp = 0;
  int n_fail = 0;

  // Per-frame observations
  int         on_cnt [4];
  logic [7:0] seg_seen [4];
  int         tick_pos, n_tick, n_ack, ack_pos, n_glitch, n_bad_cs;

  seg_scan_ctrl #(
    .N_DIG(4), .SCAN_DIV(16), .BLANK_CYC(2), .BRIGHT_W(2),
    .BLINK_FRAMES(2), .SEG_ACT_LOW(1'b1), .CS_ACT_LOW(1'b1)
  ) dut (
    .clk(clk), .RST(RST), .dig_val(dig_val), .dig_dot(dig_dot),
    .dig_ena(dig_ena), .dig_blink(dig_blink), .brightness(brightness),
    .upd_req(upd_req), .upd_ack(upd_ack), .seg_pin(seg_pin),
    .segcs_pin(segcs_pin), .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Observe one frame: samples 1..64 after a frame-start edge
  task automatic scan_frame();
    logic [7:0] prev_seg;
    logic [3:0] prev_cs;
    logic [3:0] oh;
    bit found;
    for (int d = 0; d < 4; d++) begin
      on_cnt[d] = 0;
      seg_seen[d] = 8'h00;
    end
    tick_pos = -1; n_tick = 0; n_ack = 0; ack_pos = -1; n_glitch = 0; n_bad_cs = 0;
    prev_seg = seg_pin;
    prev_cs  = segcs_pin;
    for (int j = 1; j <= 64; j++) begin
      tick();
      if (frame_tick) begin n_tick++; tick_pos = j; end
      if (upd_ack) begin n_ack++; ack_pos = j; end
      if (seg_pin !== prev_seg && (segcs_pin !== 4'hF || prev_cs !== 4'hF)) n_glitch++;
      found = 1'b0;
      for (int d = 0; d < 4; d++) begin
        oh = 4'b0001 << d;
        if (segcs_pin === ~oh) begin
          on_cnt[d]++;
          seg_seen[d] = seg_pin;
          found = 1'b1;
        end
      end
      if (!found && segcs_pin !== 4'hF) n_bad_cs++;
      prev_seg = seg_pin;
      prev_cs  = segcs_pin;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) tick();
    n_cmp++; if (segcs_pin !== 4'hF) begin n_fail++; $display("FAIL reset_cs: got %h exp f", segcs_pin); end
    n_cmp++; if (seg_pin !== 8'hFF) begin n_fail++; $display("FAIL reset_seg: got %h exp ff", seg_pin); end
    n_cmp++; if (upd_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b exp 0", upd_ack); end
    n_cmp++; if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b exp 0", frame_tick); end
    RST = 1'b0;
  endtask

  task automatic test_load_full();
    logic [7:0] exp_seg [4];
    int i;
    exp_seg[0] = 8'h99; exp_seg[1] = 8'hB0; exp_seg[2] = 8'hA4; exp_seg[3] = 8'hF9;
    dig_val = 16'h1234; dig_ena = 4'hF; brightness = 2'd3; upd_req = 1'b1;
    for (i = 0; i < 200; i++) begin
      tick();
      if (frame_tick) break;
    end
    n_cmp++; if (i >= 200) begin n_fail++; $display("FAIL load_wait_tick: got timeout exp frame_tick"); end
    n_cmp++; if (upd_ack !== 1'b0) begin n_fail++; $display("FAIL load_ack_early: got %b exp 0", upd_ack); end
    tick();
    n_cmp++; if (upd_ack !== 1'b1) begin n_fail++; $display("FAIL load_ack: got %b exp 1", upd_ack); end
    n_cmp++; if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL load_tick_pulse: got %b exp 0", frame_tick); end
    upd_req = 1'b0;
    dig_val = 16'hFFFF;
    scan_frame();
    for (int d = 0; d < 4; d++) begin
      n_cmp++; if (on_cnt[d] !== 14) begin n_fail++; $display("FAIL full_on_d%0d: got %0d exp 14", d, on_cnt[d]); end
      n_cmp++; if (seg_seen[d] !== exp_seg[d]) begin n_fail++; $display("FAIL full_seg_d%0d: got %h exp %h", d, seg_seen[d], exp_seg[d]); end
    end
    n_cmp++; if (tick_pos !== 63) begin n_fail++; $display("FAIL full_tick_pos: got %0d exp 63", tick_pos); end
    n_cmp++; if (n_ack !== 0) begin n_fail++; $display("FAIL full_no_ack: got %0d exp 0", n_ack); end
    n_cmp++; if (n_glitch !== 0) begin n_fail++; $display("FAIL full_seg_glitch: got %0d exp 0", n_glitch); end
    n_cmp++; if (n_bad_cs !== 0) begin n_fail++; $display("FAIL full_bad_cs: got %0d exp 0", n_bad_cs); end
  endtask

  task automatic test_dim();
    brightness = 2'd0;
    scan_frame();
    n_cmp++; if (on_cnt[2] !== 14) begin n_fail++; $display("FAIL dim_midframe_ignored: got %0d exp 14", on_cnt[2]); end
    n_cmp++; if (seg_seen[0] !== 8'h99) begin n_fail++; $display("FAIL no_tearing_seg: got %h exp 99", seg_seen[0]); end
    scan_frame();
    for (int d = 0; d < 4; d++) begin
      n_cmp++; if (on_cnt[d] !== 3) begin n_fail++; $display("FAIL dim_on_d%0d: got %0d exp 3", d, on_cnt[d]); end
    end
    n_cmp++; if (n_glitch !== 0) begin n_fail++; $display("FAIL dim_seg_glitch: got %0d exp 0", n_glitch); end
  endtask

  task automatic test_enable_mask();
    int exp_on [4];
    exp_on[0] = 14; exp_on[1] = 0; exp_on[2] = 14; exp_on[3] = 0;
    dig_val = 16'h1234; dig_ena = 4'b0101; brightness = 2'd3; upd_req = 1'b1;
    scan_frame();
    n_cmp++; if (on_cnt[1] !== 3) begin n_fail++; $display("FAIL mask_prev_frame: got %0d exp 3", on_cnt[1]); end
    n_cmp++; if (n_ack !== 1 || ack_pos !== 64) begin n_fail++; $display("FAIL mask_ack: got %0d@%0d exp 1@64", n_ack, ack_pos); end
    upd_req = 1'b0;
    scan_frame();
    for (int d = 0; d < 4; d++) begin
      n_cmp++; if (on_cnt[d] !== exp_on[d]) begin n_fail++; $display("FAIL mask_on_d%0d: got %0d exp %0d", d, on_cnt[d], exp_on[d]); end
    end
    n_cmp++; if (seg_seen[2] !== 8'hA4) begin n_fail++; $display("FAIL mask_seg_d2: got %h exp a4", seg_seen[2]); end
    n_cmp++; if (n_tick !== 1 || tick_pos !== 63) begin n_fail++; $display("FAIL frame_period: got %0d@%0d exp 1@63", n_tick, tick_pos); end
    n_cmp++; if (n_bad_cs !== 0) begin n_fail++; $display("FAIL mask_bad_cs: got %0d exp 0", n_bad_cs); end
  endtask

  task automatic test_back_to_back_blink();
    dig_ena = 4'hF; dig_blink = 4'b0001; dig_dot = 4'b0001; upd_req = 1'b1;
    scan_frame();
    n_cmp++; if (on_cnt[1] !== 0) begin n_fail++; $display("FAIL b2b_old_shadow: got %0d exp 0", on_cnt[1]); end
    n_cmp++; if (n_ack !== 1 || ack_pos !== 64) begin n_fail++; $display("FAIL b2b_ack1: got %0d@%0d exp 1@64", n_ack, ack_pos); end
    scan_frame();
    n_cmp++; if (n_ack !== 1 || ack_pos !== 64) begin n_fail++; $display("FAIL b2b_ack2: got %0d@%0d exp 1@64", n_ack, ack_pos); end
    n_cmp++; if (on_cnt[0] !== 0) begin n_fail++; $display("FAIL blink_off_f7: got %0d exp 0", on_cnt[0]); end
    n_cmp++; if (on_cnt[1] !== 14) begin n_fail++; $display("FAIL blink_other_f7: got %0d exp 14", on_cnt[1]); end
    n_cmp++; if (seg_seen[1] !== 8'hB0) begin n_fail++; $display("FAIL dot_only_d0: got %h exp b0", seg_seen[1]); end
    upd_req = 1'b0;
    scan_frame();
    n_cmp++; if (on_cnt[0] !== 14) begin n_fail++; $display("FAIL blink_on_f8: got %0d exp 14", on_cnt[0]); end
    n_cmp++; if (seg_seen[0] !== 8'h19) begin n_fail++; $display("FAIL dot_seg_d0: got %h exp 19", seg_seen[0]); end
    n_cmp++; if (n_ack !== 0) begin n_fail++; $display("FAIL req_dropped_ack: got %0d exp 0", n_ack); end
    scan_frame();
    n_cmp++; if (on_cnt[0] !== 14) begin n_fail++; $display("FAIL blink_on_f9: got %0d exp 14", on_cnt[0]); end
    scan_frame();
    n_cmp++; if (on_cnt[0] !== 0) begin n_fail++; $display("FAIL blink_off_f10: got %0d exp 0", on_cnt[0]); end
    n_cmp++; if (on_cnt[3] !== 14) begin n_fail++; $display("FAIL blink_other_f10: got %0d exp 14", on_cnt[3]); end
  endtask

  task automatic test_mid_reset();
    repeat (20) tick();
    n_cmp++; if (segcs_pin !== 4'b1101) begin n_fail++; $display("FAIL premid_cs: got %b exp 1101", segcs_pin); end
    RST = 1'b1;
    #1;
    n_cmp++; if (segcs_pin !== 4'hF) begin n_fail++; $display("FAIL async_cs: got %h exp f", segcs_pin); end
    n_cmp++; if (seg_pin !== 8'hFF) begin n_fail++; $display("FAIL async_seg: got %h exp ff", seg_pin); end
    repeat (2) tick();
    RST = 1'b0;
    scan_frame();
    for (int d = 0; d < 4; d++) begin
      n_cmp++; if (on_cnt[d] !== 0) begin n_fail++; $display("FAIL shadow_clear_d%0d: got %0d exp 0", d, on_cnt[d]); end
    end
    n_cmp++; if (n_tick !== 1 || tick_pos !== 63) begin n_fail++; $display("FAIL restart_tick: got %0d@%0d exp 1@63", n_tick, tick_pos); end
  endtask

  initial begin
    RST = 1'b1; dig_val = '0; dig_dot = '0; dig_ena = '0; dig_blink = '0;
    brightness = '0; upd_req = 1'b0;
    test_reset();
    test_load_full();
    test_dim();
    test_enable_mask();
    test_back_to_back_blink();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
